instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Producer side of the main control decoder's interface: fetches 32-bit instruction words from instruction memory over a req/ready handshake.
- Holds each word in an instruction register and presents `op` (instr[31:26]) to the decoder.
- Sequences the PC using the decoder's Branch/Jump outputs and the ALU Zero flag.
- Sits between imem and the control/datapath of the multi-cycle MIPS core (R-type, ori, lw, sw, beq, j).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
- HALT_ON_ILLEGAL, 1, when 1 an unsupported opcode stops fetching until reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  imem_rdata valid this cycle; completes request
- imem_rdata  in  32  instruction word
- instr  out  32  instruction register
- op  out  6  instr[31:26], to control decoder
- instr_valid  out  1  instr/op valid for execution
- pc  out  32  address of instruction in instr
- branch  in  1  decoder Branch
- jump  in  1  decoder Jump
- zero  in  1  ALU zero flag
- retire  in  1  datapath finished current instruction
- illegal  out  1  sticky: unsupported opcode fetched

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, illegal=0.
  - imem_req is driven 0 while reset is high; it is 1 in FETCH thereafter.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, both stable until imem_ready.
  - On imem_ready: instr<=imem_rdata, go to EXEC.
  - Opcode legal set: 000000, 001101, 100011, 101011, 000100, 000010.
  - If the fetched opcode is not in the legal set: illegal<=1, and go to HALT instead of EXEC when HALT_ON_ILLEGAL=1.
  - Request-to-data latency: 0..N cycles of imem wait. instr_valid rises the cycle after imem_ready.
- EXEC:
  - imem_req=0, instr_valid=1, instr/pc held.
  - On retire: pc<=next_pc, instr_valid<=0, go to FETCH. The next request is asserted in the following cycle.
  - branch/jump/zero are sampled only in the retire cycle.
- HALT: imem_req=0, instr_valid=0, illegal=1. Only reset exits.
- next_pc (all arithmetic mod 2^32):
  - p4 = pc+4.
  - jump=1: {p4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - Else branch&zero: p4 + (signext(instr[15:0])<<2).
  - Else p4.
- Boundaries:
  - pc=FFFF_FFFC sequential → 0000_0000 (wrap, no flag).
  - imem_ready while imem_req=0 is ignored.
  - retire outside EXEC is ignored.
  - reset asserted mid-fetch drops imem_req that cycle; an outstanding response is not captured.
  - pc[1:0] is always 0.

Decomposition:
- Package mips_pkg:
  - opcode constants OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - fetch state encoding.
  - default RESET_PC.
  - is_legal_op function.
  - Shared with the control decoder.
- Sub-module next_pc_calc: combinational; inputs pc, instr, branch, jump, zero; output next_pc.

Test Plan:
- Reset release, imem_ready tied 1, rdata=0x00000020, retire after 1 cycle each → addresses 0x0, 0x4, 0x8. op=000000. instr_valid high one cycle after each ready.
- imem_ready delayed 3 cycles → imem_addr/imem_req stable all 3 cycles. instr_valid stays 0 until cycle after ready.
- pc=0x100, instr=0x1000FFFE (beq, imm -2):
  - branch=1, zero=1 at retire → next addr 0x0FC.
  - zero=0 → next addr 0x104.
- pc=0x1000_0040, instr=0x08000010 (j), jump=1, branch=1, zero=1 → next addr 0x1000_0040 (jump wins).
- Fetch of 0xFC000000 (op 111111) → illegal=1, HALT. imem_req stays 0 for 20 cycles; reset clears illegal and restarts at RESET_PC.
- RESET_PC=FFFF_FFFC, non-branch instr retired → next fetch 0x0.
- Reset pulsed while waiting on imem_ready → imem_req falls in the same cycle; instr stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch state encoding and the supported-opcode check.
// The main control decoder imports the same package.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: a jump overrides a taken branch, which overrides pc+4.
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] p4;
    logic [31:0] br_offset;

    always_comb begin
        p4        = pc + 32'd4;
        br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (jump) begin
            next_pc = {p4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = p4 + br_offset;
        end else begin
            next_pc = p4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches instruction words over the imem req/ready handshake, holds them for execution
// and advances the PC on retire; an unsupported opcode sets a sticky flag and may halt.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        retire,
    output logic        illegal
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         illegal_q, illegal_d;
    logic [31:0]  next_pc;

    next_pc_calc u_next_pc_calc (
        .pc      (pc_q),
        .instr   (instr_q),
        .branch  (branch),
        .jump    (jump),
        .zero    (zero),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            instr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    if (!is_legal_op(imem_rdata[31:26])) begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? HALT : EXEC;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (retire) begin
                    pc_d    = {next_pc[31:2], 2'b00};
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Gating with reset drops the request combinationally while reset is held.
    assign imem_req    = (state_q == FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign instr_valid = (state_q == EXEC);
    assign pc          = pc_q;
    assign illegal     = illegal_q;

endmodule
